// File: rtl/led_racer_pkg.sv
// led_racer_pkg: screen codes, pixel type and player colour table shared by the frame engine
package led_racer_pkg;
  typedef enum logic [1:0] {MENU = 2'd0, COUNTDOWN = 2'd1, RACE = 2'd2, WIN = 2'd3} screen_t;
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } rgb_t;
  localparam rgb_t COLOR [8] = '{
    '{8'h30, 8'h00, 8'h00},
    '{8'h00, 8'h30, 8'h00},
    '{8'h00, 8'h00, 8'h30},
    '{8'h30, 8'h30, 8'h00},
    '{8'h30, 8'h00, 8'h30},
    '{8'h00, 8'h30, 8'h30},
    '{8'h18, 8'h30, 8'h00},
    '{8'h10, 8'h30, 8'h18}
  };
  localparam rgb_t WHITE = '{8'h10, 8'h10, 8'h10};
endpackage

// File: rtl/pixel_colorizer.sv
// pixel_colorizer: colour of one LED from a frame snapshot, screen and blink phase
module pixel_colorizer
  import led_racer_pkg::*;
#(
  parameter int MAX_POS     = 16,
  parameter int NUM_PLAYERS = 4
) (
  input  logic [NUM_PLAYERS*$clog2(MAX_POS)-1:0] i_pos,
  input  logic [NUM_PLAYERS-1:0]                 i_ready,
  input  logic [2:0]                             i_countdown,
  input  logic [1:0]                             i_screen,
  input  logic [$clog2(MAX_POS)-1:0]             i_idx,
  input  logic                                   i_blink_phase,
  output logic [23:0]                            o_rgb
);
  localparam int PW = $clog2(MAX_POS);
  localparam logic [PW-1:0] LAST = PW'(MAX_POS - 1);
  rgb_t w_menu, w_race, w_win;
  // descending scan so the lowest matching player is written last and wins
  always_comb begin
    w_menu = '0;
    w_race = '0;
    w_win  = '0;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      if (i_ready[k] && 32'(i_idx) == k) w_menu = COLOR[k];
      if (i_ready[k] && i_pos[k*PW +: PW] == i_idx) w_race = COLOR[k];
      if (i_pos[k*PW +: PW] == LAST) w_win = i_ready[k] ? COLOR[k] : '0;
    end
    o_rgb = i_screen == MENU      ? w_menu :
            i_screen == COUNTDOWN ? ((32'(i_idx) < 32'(i_countdown)) ? WHITE : '0) :
            i_screen == RACE      ? w_race :
            i_blink_phase         ? w_win  : '0;
  end
endmodule

// File: rtl/display_frame_engine.sv
// display_frame_engine: merges activity into frame requests, snapshots game state and
// streams one registered RGB pixel per LED over valid/ready, with a self-timed WIN blink
module display_frame_engine
  import led_racer_pkg::*;
#(
  parameter int MAX_POS      = 16,
  parameter int NUM_PLAYERS  = 4,
  parameter int BLINK_CYCLES = 6_000_000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_PLAYERS-1:0]                 player_ready,
  input  logic [NUM_PLAYERS*$clog2(MAX_POS)-1:0] player_pos,
  input  logic [NUM_PLAYERS-1:0]                 player_activity,
  input  logic                                   menu_activity,
  input  logic                                   is_in_menu,
  input  logic [2:0]                             countdown,
  output logic [1:0]                             current_screen,
  output logic                                   pix_valid,
  input  logic                                   pix_ready,
  output logic [$clog2(MAX_POS)-1:0]             pix_index,
  output logic [7:0]                             pix_g,
  output logic [7:0]                             pix_r,
  output logic [7:0]                             pix_b,
  output logic                                   frame_done,
  output logic                                   busy
);
  localparam int PW = $clog2(MAX_POS);
  localparam int BW = $clog2(BLINK_CYCLES);
  localparam logic [PW-1:0] LAST = PW'(MAX_POS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_SNAP = 2'd1, S_STREAM = 2'd2, S_DONE = 2'd3;
  logic [1:0] r_state;
  logic r_pending, r_phase, r_snap_phase;
  logic [BW-1:0] r_cnt;
  logic [NUM_PLAYERS*PW-1:0] r_pos;
  logic [NUM_PLAYERS-1:0] r_ready;
  logic [2:0] r_cd;
  screen_t r_screen, w_screen;
  logic [PW-1:0] r_idx, w_cidx;
  rgb_t r_pix, w_rgb;
  logic w_any_win, w_toggle, w_snap, w_req;
  always_comb begin
    w_any_win = 1'b0;
    for (int k = 0; k < NUM_PLAYERS; k++) w_any_win |= player_pos[k*PW +: PW] == LAST;
  end
  assign w_screen = is_in_menu ? MENU : countdown != 3'd0 ? COUNTDOWN : w_any_win ? WIN : RACE;
  assign w_snap   = r_state == S_SNAP;
  assign w_toggle = r_screen == WIN && r_cnt == B_LAST;
  assign w_req    = |player_activity | menu_activity | w_toggle;
  assign w_cidx   = w_snap ? '0 : r_idx + 1'b1;
  // during SNAP the colorizer sees the live inputs so pixel 0 is ready on the first STREAM cycle
  pixel_colorizer #(.MAX_POS(MAX_POS), .NUM_PLAYERS(NUM_PLAYERS)) u_colorizer (
    .i_pos        (w_snap ? player_pos : r_pos),
    .i_ready      (w_snap ? player_ready : r_ready),
    .i_countdown  (w_snap ? countdown : r_cd),
    .i_screen     (w_snap ? w_screen : r_screen),
    .i_idx        (w_cidx),
    .i_blink_phase(w_snap ? r_phase : r_snap_phase),
    .o_rgb        (w_rgb)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pending    <= 1'b1;
      r_phase      <= 1'b0;
      r_snap_phase <= 1'b0;
      r_cnt        <= '0;
      r_screen     <= MENU;
      r_idx        <= '0;
      r_pix        <= '0;
      r_pos        <= '0;
      r_ready      <= '0;
      r_cd         <= '0;
    end else begin
      r_pending <= w_req | (r_pending & ~w_snap);
      r_cnt     <= (r_screen != WIN || w_toggle) ? '0 : r_cnt + 1'b1;
      r_phase   <= r_screen == WIN && (r_phase ^ w_toggle);
      case (r_state)
        S_IDLE: if (r_pending) r_state <= S_SNAP;
        S_SNAP: begin
          r_state      <= S_STREAM;
          r_pos        <= player_pos;
          r_ready      <= player_ready;
          r_cd         <= countdown;
          r_screen     <= w_screen;
          r_snap_phase <= r_phase;
          r_idx        <= '0;
          r_pix        <= w_rgb;
        end
        S_STREAM: if (pix_ready) begin
          if (r_idx == LAST) r_state <= S_DONE;
          else begin
            r_idx <= r_idx + 1'b1;
            r_pix <= w_rgb;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign pix_valid      = r_state == S_STREAM;
  assign frame_done     = r_state == S_DONE;
  assign busy           = r_state != S_IDLE;
  assign pix_index      = r_idx;
  assign {pix_g, pix_r, pix_b} = r_pix;
  assign current_screen = r_screen;
endmodule

// File: tb/tb_display_frame_engine.sv
// tb_display_frame_engine: table-driven frame checks plus stall, mid-frame request, blink and reset sequences
module tb_display_frame_engine;
  localparam logic [23:0] G = 24'h300000, R = 24'h003000, B = 24'h000030, Y = 24'h303000, W = 24'h101010;
  logic clk = 1'b0, reset, pix_ready, menu_activity, is_in_menu;
  logic [3:0] player_ready, player_activity, pix_index;
  logic [15:0] player_pos;
  logic [2:0] countdown;
  logic [1:0] current_screen;
  logic pix_valid, frame_done, busy;
  logic [7:0] pix_g, pix_r, pix_b;
  int total = 0, bad = 0;
  logic [23:0] fr [16];
  int fr_n, fr_scr;
  typedef struct {
    logic menu; logic [2:0] cd; logic [3:0] rdy; logic [15:0] pos;
    int scr; int i0; int c0; int i1; int c1; int nlit;
  } vec_t;
  vec_t v [6];

  always #5 clk = ~clk;

  // blink half-period longer than one 19-cycle frame, so every toggle yields exactly one frame
  display_frame_engine #(.MAX_POS(16), .NUM_PLAYERS(4), .BLINK_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .player_ready(player_ready), .player_pos(player_pos),
    .player_activity(player_activity), .menu_activity(menu_activity), .is_in_menu(is_in_menu),
    .countdown(countdown), .current_screen(current_screen), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_index(pix_index), .pix_g(pix_g), .pix_r(pix_r), .pix_b(pix_b),
    .frame_done(frame_done), .busy(busy)
  );

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic capture(input bit rnd);
    int cyc = 0, bad_idx = 0, bad_stall = 0;
    bit done = 0, stall = 0, last = 0;
    logic [27:0] prev = '0;
    fr_n = 0;
    fr_scr = -1;
    for (int i = 0; i < 16; i++) fr[i] = 24'hxxxxxx;
    while (!done && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (last) check("done_after_last", int'(frame_done), 1);
      last = 0;
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall && {pix_index, pix_g, pix_r, pix_b} !== prev) bad_stall++;
      if (pix_valid) fr_scr = int'(current_screen);
      if (pix_valid && pix_ready) begin
        if (int'(pix_index) != fr_n) bad_idx++;
        if (fr_n < 16) fr[fr_n] = {pix_g, pix_r, pix_b};
        last = fr_n == 15;
        fr_n++;
      end
      stall = pix_valid && !pix_ready;
      prev = {pix_index, pix_g, pix_r, pix_b};
      done = frame_done;
    end
    pix_ready = 1'b1;
    check("frame_timeout", int'(done), 1);
    check("pixel_count", fr_n, 16);
    check("index_order", bad_idx, 0);
    check("stall_hold", bad_stall, 0);
  endtask

  task automatic check_frame(input string nm, input int scr, input int i0, input int c0,
                             input int i1, input int c1, input int nl);
    int lit = 0;
    for (int i = 0; i < 16; i++) if (fr[i] !== 24'h0) lit++;
    check({nm, "_screen"}, fr_scr, scr);
    check($sformatf("%s_px%0d", nm, i0), int'(fr[i0]), c0);
    check($sformatf("%s_px%0d", nm, i1), int'(fr[i1]), c1);
    check({nm, "_lit"}, lit, nl);
  endtask

  task automatic pulse_menu;
    menu_activity = 1'b1;
    @(negedge clk);
    menu_activity = 1'b0;
  endtask

  task automatic pulse_player(input logic [3:0] m);
    player_activity = m;
    @(negedge clk);
    player_activity = 4'b0;
  endtask

  initial begin
    int w, ex, same;
    reset = 1'b1; pix_ready = 1'b1; menu_activity = 1'b0; is_in_menu = 1'b1;
    player_ready = 4'b0; player_activity = 4'b0; player_pos = 16'h0; countdown = 3'd0;
    v[0] = '{1'b1, 3'd0, 4'b0101, 16'h0000, 0, 0, G, 2, B, 2};
    v[1] = '{1'b1, 3'd3, 4'b1000, 16'h0000, 0, 3, Y, 0, 0, 1};
    v[2] = '{1'b0, 3'd0, 4'b0111, 16'h9553, 2, 5, R, 3, G, 2};
    v[3] = '{1'b0, 3'd0, 4'b1100, 16'h0000, 2, 0, B, 1, 0, 1};
    v[4] = '{1'b0, 3'd3, 4'b1111, 16'h3210, 1, 2, W, 3, 0, 3};
    v[5] = '{1'b0, 3'd7, 4'b1111, 16'hF000, 1, 6, W, 7, 0, 7};
    repeat (3) @(negedge clk);
    check("rst_valid", int'(pix_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_screen", int'(current_screen), 0);
    check("rst_pixel", int'({pix_g, pix_r, pix_b}), 0);
    check("rst_index", int'(pix_index), 0);
    reset = 1'b0;
    capture(0);
    check_frame("boot", 0, 0, 0, 15, 0, 0);
    for (int i = 0; i < 6; i++) begin
      is_in_menu = v[i].menu; countdown = v[i].cd;
      player_ready = v[i].rdy; player_pos = v[i].pos;
      pulse_menu();
      capture(0);
      check_frame($sformatf("vec%0d", i), v[i].scr, v[i].i0, v[i].c0, v[i].i1, v[i].c1, v[i].nlit);
    end
    // mid-frame request under random backpressure: old frame intact, exactly one more frame
    is_in_menu = 1'b0; countdown = 3'd0; player_ready = 4'b1111; player_pos = 16'h3210;
    pulse_player(4'b0001);
    fork
      capture(1);
      begin
        int k = 0;
        while (!(pix_valid && pix_index == 4'd6) && k < 300) begin
          @(negedge clk);
          k++;
        end
        player_pos = 16'h7654;
        pulse_player(4'b0010);
      end
    join
    check_frame("tear1", 2, 0, G, 4, 0, 4);
    capture(1);
    check_frame("tear2", 2, 4, G, 0, 0, 4);
    ex = 0;
    repeat (60) begin
      @(negedge clk);
      if (pix_valid) ex++;
    end
    check("no_third_frame", ex, 0);
    // WIN blink: off, green, off, green
    player_ready = 4'b0001; player_pos = 16'h000F;
    pulse_player(4'b0001);
    for (int f = 0; f < 4; f++) begin
      capture(0);
      same = 0;
      for (int i = 0; i < 16; i++) if (fr[i] === ((f % 2 == 1) ? G : 24'h0)) same++;
      check($sformatf("win%0d_screen", f), fr_scr, 3);
      check($sformatf("win%0d_uniform", f), same, 16);
    end
    w = 0;
    while (!(pix_valid && pix_index == 4'd7) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("reset_wait", int'(w < 200), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_valid", int'(pix_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(frame_done), 0);
    check("abort_screen", int'(current_screen), 0);
    reset = 1'b0;
    capture(0);
    check_frame("after_abort", 3, 0, 0, 15, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
